data_sram_like_responder: RTL
=============================

Name: data_sram_like_responder

Overview:
- Slave/responder end of the SRAM-like data interface (req/addr_ok, then data_ok/rdata) driven by the CPU memory pipeline.
- Accepts read and write requests into a local word-addressed RAM and returns exactly one in-order data_ok pulse per accepted request after a programmable minimum latency.
- Supports multiple outstanding requests.
- Used as the data-side memory model and bench responder for the pipeline.

Parameters:
- MEM_AW, 10, word-address width of local RAM (2^MEM_AW words of 32 bits).
- OUTST_DEPTH, 4, maximum outstanding accepted-but-unanswered requests (power of 2, >=2).
- RESP_LAT, 2, minimum cycles from request handshake to data_ok (>=1).

Ports:
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- data_sram_req  in  1  request valid.
- data_sram_wr  in  1  1 = write, 0 = read.
- data_sram_size  in  2  0 = byte, 1 = half, 2 = word (informational; wstrb governs writes).
- data_sram_wstrb  in  4  byte enables for writes.
- data_sram_addr  in  32  byte address; RAM index is addr[MEM_AW+1:2].
- data_sram_wdata  in  32  write data.
- data_sram_addr_ok  out  1  request accepted this cycle when high together with req.
- data_sram_data_ok  out  1  one-cycle response pulse.
- data_sram_rdata  out  32  full read word, valid with data_ok.
- outst_cnt  out  $clog2(OUTST_DEPTH)+1  current outstanding count (debug/bench).

Behaviour:
- Reset values: addr_ok 0 (forced low while resetn low), data_ok 0, rdata 32'h0, outst_cnt 0. Queue pointers and counters are cleared. RAM contents are not reset.
- Reset mid-operation: all outstanding entries are dropped and no data_ok is issued for them. The first cycle after release behaves as empty.
- Handshake: a request is accepted in cycle n iff req && addr_ok in cycle n.
  - addr_ok = resetn && (outst_cnt < OUTST_DEPTH) [&& stall gate, see Optional Feature].
  - addr_ok does not depend on req.
  - No bypass: when the queue is full, addr_ok stays low even if a pop occurs in the same cycle.
- Write on accept: masked byte write of wdata into RAM[index] using wstrb at the end of cycle n. wstrb 0000 writes nothing but still produces a response.
- Read on accept: RAM[index] is sampled at accept and stored in the queue entry. A read accepted in the cycle after a write to the same word returns the new data.
  - Same-cycle read/write cannot occur: one request per cycle.
- Queue entry: {is_wr, rdata[31:0], lat_cnt}.
  - lat_cnt is loaded with RESP_LAT-1 at accept.
  - Each valid entry with lat_cnt>0 decrements every cycle.
- Response: data_ok is high in a cycle iff the head entry is valid and its lat_cnt==0; the head is popped at the end of that cycle.
  - data_ok high in cycle n+RESP_LAT at the earliest.
  - Strictly in acceptance order; at most one response per cycle.
  - Back-to-back accepts give back-to-back data_ok.
- rdata: head entry data while data_ok is high, 32'h0 otherwise. Writes return 32'h0.
- No response backpressure: the master must consume every data_ok. A master that has cancelled a request still receives its data_ok.
- Simultaneous push and pop: outst_cnt is unchanged. Pointers wrap modulo OUTST_DEPTH.
- outst_cnt increments on accept-only, decrements on pop-only.

Optional Feature:
- Macro: DSRAM_ADDR_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) is seeded to 16'hACE1 on reset and advances every cycle.
  - addr_ok is additionally forced low whenever lfsr[1:0]==2'b00.
  - Sequence is deterministic after reset. Responses and ordering are otherwise unchanged.
- Undefined: the LFSR is absent and addr_ok depends only on reset and occupancy.

Test Plan:
- Write then read, RESP_LAT=2:
  - Stimulus: write addr 0x100, wdata 0xDEADBEEF, wstrb 1111 in cycle 0; read 0x100 in cycle 1.
  - Required: data_ok in cycles 2 and 3; rdata 0x0 in cycle 2, 0xDEADBEEF in cycle 3.
- Byte strobe merge:
  - Stimulus: word 0x11223344 present; write wstrb 0100, wdata 0xAABBCCDD to the same address; then read.
  - Required: rdata 0x11BB3344.
- Full queue, OUTST_DEPTH=4, RESP_LAT=8:
  - Stimulus: req held high with reads.
  - Required: 4 accepts in cycles 0-3, addr_ok low in cycles 4-7, outst_cnt 4; first data_ok in cycle 8, addr_ok high again in cycle 9.
- Ordering:
  - Stimulus: 6 reads to addresses 0x0, 0x4, ... 0x14 pre-filled with values 0-5.
  - Required: six data_ok pulses carrying rdata 0, 1, 2, 3, 4, 5 in order; count of data_ok equals count of accepts.
- Reset mid-flight:
  - Stimulus: 3 requests outstanding; resetn pulsed low mid-cycle.
  - Required: addr_ok and data_ok drop to 0 immediately; after release no data_ok until a new accept; earlier written RAM data is still readable.
- With DSRAM_ADDR_STALL_EN defined:
  - Stimulus: 100 continuous requests.
  - Required: addr_ok low exactly in cycles where lfsr[1:0]==0 (checked against reference LFSR model); all accepted requests answered in order.

Source files
------------

// File: rtl/data_sram_like_responder.sv
// Responder end of the SRAM-like data interface: local word RAM plus an in-order response queue.
// Optional macro DSRAM_ADDR_STALL_EN adds deterministic LFSR-driven addr_ok stalls.
module data_sram_like_responder #(
    parameter int MEM_AW      = 10,
    parameter int OUTST_DEPTH = 4,
    parameter int RESP_LAT    = 2
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         data_sram_req,
    input  logic                         data_sram_wr,
    input  logic [1:0]                   data_sram_size,
    input  logic [3:0]                   data_sram_wstrb,
    input  logic [31:0]                  data_sram_addr,
    input  logic [31:0]                  data_sram_wdata,
    output logic                         data_sram_addr_ok,
    output logic                         data_sram_data_ok,
    output logic [31:0]                  data_sram_rdata,
    output logic [$clog2(OUTST_DEPTH):0] outst_cnt
);
    localparam int PW = $clog2(OUTST_DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(OUTST_DEPTH);
    localparam logic [LW-1:0] LAT_INIT_C = LW'(RESP_LAT - 1);

    logic [31:0]            mem_r [2**MEM_AW];
    logic [OUTST_DEPTH-1:0] q_vld_r;
    logic [OUTST_DEPTH-1:0] q_wr_r;
    logic [31:0]            q_data_r [OUTST_DEPTH];
    logic [LW-1:0]          q_lat_r [OUTST_DEPTH];
    logic [PW-1:0]          head_r;
    logic [PW-1:0]          tail_r;
    logic [CW-1:0]          cnt_r;
    logic [MEM_AW-1:0]      idx_s;
    logic                   accept_s;
    logic                   pop_s;
    logic                   stall_s;
    logic                   unused_s;

`ifdef DSRAM_ADDR_STALL_EN
    logic [15:0] lfsr_r;

    // Free-running stall generator; restarts from a fixed seed on every reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_r <= 16'hACE1;
        end else begin
            lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
        end
    end

    assign stall_s = (lfsr_r[1:0] == 2'b00);
`else
    assign stall_s = 1'b0;
`endif

    assign idx_s             = data_sram_addr[MEM_AW+1:2];
    // No bypass: a pop in the same cycle does not reopen a full queue.
    assign data_sram_addr_ok = resetn & (cnt_r < DEPTH_C) & ~stall_s;
    assign accept_s          = data_sram_req & data_sram_addr_ok;
    assign data_sram_data_ok = q_vld_r[head_r] & (q_lat_r[head_r] == {LW{1'b0}});
    assign pop_s             = data_sram_data_ok;
    assign data_sram_rdata   = (data_sram_data_ok & ~q_wr_r[head_r]) ? q_data_r[head_r] : 32'h0;
    assign outst_cnt         = cnt_r;
    assign unused_s          = ^{data_sram_size, data_sram_addr[31:MEM_AW+2], data_sram_addr[1:0]};

    // Byte-masked RAM write on an accepted write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (accept_s && data_sram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram_wstrb[b]) begin
                    mem_r[idx_s][8*b +: 8] <= data_sram_wdata[8*b +: 8];
                end
            end
        end
    end

    // Response queue: push on accept, age every waiting entry, pop the head once it is due.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_vld_r <= {OUTST_DEPTH{1'b0}};
            q_wr_r  <= {OUTST_DEPTH{1'b0}};
            for (int i = 0; i < OUTST_DEPTH; i++) begin
                q_data_r[i] <= 32'h0;
                q_lat_r[i]  <= {LW{1'b0}};
            end
            head_r <= {PW{1'b0}};
            tail_r <= {PW{1'b0}};
            cnt_r  <= {CW{1'b0}};
        end else begin
            for (int i = 0; i < OUTST_DEPTH; i++) begin
                if (q_vld_r[i] && (q_lat_r[i] != {LW{1'b0}})) begin
                    q_lat_r[i] <= q_lat_r[i] - LW'(1);
                end
            end
            if (pop_s) begin
                q_vld_r[head_r] <= 1'b0;
                head_r          <= head_r + PW'(1);
            end
            if (accept_s) begin
                q_vld_r[tail_r]  <= 1'b1;
                q_wr_r[tail_r]   <= data_sram_wr;
                q_data_r[tail_r] <= data_sram_wr ? 32'h0 : mem_r[idx_s];
                q_lat_r[tail_r]  <= LAT_INIT_C;
                tail_r           <= tail_r + PW'(1);
            end
            case ({accept_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CW'(1);
                2'b01:   cnt_r <= cnt_r - CW'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end
endmodule
